weight_update_sequencer: RTL and testbench
==========================================

# weight_update_sequencer

Sequential back-propagation write-back stage, directly downstream of the delta-computation stage. On a `start` pulse it latches the output-layer and hidden-layer deltas, their signs and the layer activations. It then walks all 65 weight words of the shared weight RAM: read, compute `w ± ((delta·act) >> LR_SHIFT)`, saturate, write back. It raises `done` when the full pass completes.

## Interface
- `DATA_W`, 10: width of weights, deltas and activations.
- `ADDR_W`, 7: weight RAM address width.
- `LR_SHIFT`, 12: learning rate expressed as a right shift of the 20-bit product.

Ports:
- `Clock` in 1: single clock; all logic on rising edge.
- `Rst` in 1: synchronous, active-high reset.
- `start` in 1: begin one update pass; sampled only in IDLE.
- `delta1[0:2]` in 3×DATA_W: output-layer delta magnitudes, unsigned.
- `sign1` in 3: output-layer delta signs; 1 = decrease weight.
- `delta0[0:4]` in 5×DATA_W: hidden-layer delta magnitudes, unsigned.
- `sign0` in 5: hidden-layer delta signs; 1 = decrease weight.
- `out0_cal[0:4]` in 5×DATA_W: hidden activations, unsigned; these are the inputs to the output layer.
- `x_in[0:9]` in 10×DATA_W: network input features, unsigned; these are the inputs to the hidden layer.
- `ram_addr` out ADDR_W: weight RAM address.
- `ram_re` out 1: RAM read enable; data returns on `ram_rdata` the next cycle.
- `ram_rdata` in DATA_W: signed weight read data.
- `ram_we` out 1: RAM write enable.
- `ram_wdata` out DATA_W: signed updated weight.
- `busy` out 1: pass in progress.
- `done` out 1: one-cycle completion pulse.

## Operation
- **Address map:**
  - Hidden neuron h (0..4) weight i (0..9) is at address 10h+i; its activation is `x_in[i]` and its delta is `delta0[h]`/`sign0[h]`.
  - Output neuron k (0..2) weight j (0..4) is at address 50+5k+j; its activation is `out0_cal[j]` and its delta is `delta1[k]`/`sign1[k]`.
- Addresses are processed in ascending order, 0..64.
- **Latching:** on accepted `start`, all delta, sign and activation inputs are registered. Input changes during the pass have no effect.
- **FSM states:** IDLE, READ, WAIT, WRITE, DONE.
  - IDLE→READ on `start`.
  - READ→WAIT always.
  - WAIT→WRITE always.
  - WRITE→READ if addr<64, with addr incremented.
  - WRITE→DONE if addr==64.
  - DONE→IDLE always.
- **Arithmetic:**
  - `prod` = delta·act, 20 bits unsigned.
  - `step` = `prod >> LR_SHIFT`, zero-extended.
  - `new` = `w − step` if sign=1, else `w + step`, computed at DATA_W+11 bits signed.
  - `new` saturates to [−512, 511].
- `ram_re` is high only in READ; `ram_we` is high only in WRITE. `ram_addr` holds the current address in READ, WAIT and WRITE.
- `start` while busy is ignored. `start` in the same cycle as `Rst` is ignored.
- **Reset mid-pass:** next state is IDLE, with no further RAM read or write. Weights already written stay written.
- **Reset values:** `ram_addr`=0, `ram_re`=0, `ram_we`=0, `ram_wdata`=0, `busy`=0, `done`=0, state IDLE.

## Timing
- `start` is high at edge t.
- READ runs in cycle t+1, with address 0 and `busy`=1 from t+1.
- WAIT is cycle t+2; `ram_rdata` is valid in this cycle and is registered.
- WRITE is cycle t+3, with `ram_we` and `ram_wdata` valid.
- Each weight takes 3 cycles. The last WRITE is cycle t+195.
- `done`=1 in cycle t+196, when `busy`=0.
- Total latency from `start` to `done` is 196 cycles.
- A new `start` is accepted from cycle t+197, once the FSM is back in IDLE.
- `ram_wdata` is registered, so it holds its last value outside WRITE.

## Structure
- **Shared package `nn_pkg`:** `N_IN`=10, `N_HID`=5, `N_OUT`=3, `HID_BASE`=0, `OUT_BASE`=50, `LAST_ADDR`=64, and the state enum `wus_state_t`.
- **Sub-module `weight_step_alu`:** combinational multiply, shift, add/subtract and saturate. Inputs are w, delta, act and sign; output is `new`. It is verified standalone.
- The address-to-(layer, neuron, index) decode is a counter pair (neuron, index) plus a layer flag, not a divider.

## Test plan
- **Basic update:** all deltas 256, sign 0, all activations 512, RAM preloaded with 100 everywhere, `start` → every address written with 132, and `done` at start+196.
- **Decrease path:** `sign1`=3'b111, `delta1`=1023, `out0_cal`=1023, weight 500 at addresses 50..64 → step 255, writes 245. Hidden addresses follow `sign0` independently.
- **Saturation:** weight 500, step 255, sign 0 → write 511. Weight −500, step 255, sign 1 → write −512.
- **Mapping check:** unique deltas/activations per neuron, e.g. `delta0[h]`=64(h+1), `x_in[i]`=64(i+1), weights 0 → address 10h+i holds (64(h+1)·64(i+1))>>12. Same pattern for the output layer at 50+5k+j.
- **Reset mid-pass:** assert `Rst` during the WRITE of address 20 → no write to address 20 or later, `busy`/`done` go to 0, and a following `start` restarts at address 0.
- **Input isolation:** change all inputs and pulse `start` again at start+50 → written values match the originally latched inputs, and only one `done` occurs.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared constants and state encoding for the weight write-back stage.
package nn_pkg;

    localparam int unsigned N_IN      = 10;
    localparam int unsigned N_HID     = 5;
    localparam int unsigned N_OUT     = 3;
    localparam int unsigned HID_BASE  = 0;
    localparam int unsigned OUT_BASE  = 50;
    localparam int unsigned LAST_ADDR = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_WRITE,
        ST_DONE
    } wus_state_t;

endpackage

// File: rtl/weight_step_alu.sv
// Single weight update: w +/- ((delta*act) >> LR_SHIFT), saturated to DATA_W signed.
module weight_step_alu #(
    parameter int unsigned DATA_W   = 10,
    parameter int unsigned LR_SHIFT = 12
) (
    input  logic signed [DATA_W-1:0] w,
    input  logic        [DATA_W-1:0] delta,
    input  logic        [DATA_W-1:0] act,
    input  logic                     sign,
    output logic signed [DATA_W-1:0] new_w
);

    localparam int unsigned PW = 2 * DATA_W;
    localparam int unsigned EW = DATA_W + 11;
    localparam logic signed [EW-1:0] SAT_MAX = EW'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [EW-1:0] SAT_MIN = ~SAT_MAX;

    logic        [PW-1:0] prod;
    logic        [PW-1:0] step;
    logic signed [EW-1:0] w_ext;
    logic signed [EW-1:0] step_ext;
    logic signed [EW-1:0] sum;

    // Multiply, scale by the learning-rate shift, apply signed step and clamp.
    always_comb begin
        prod     = PW'(delta) * PW'(act);
        step     = prod >> LR_SHIFT;
        w_ext    = {{(EW - DATA_W){w[DATA_W-1]}}, w};
        step_ext = EW'(step);
        sum      = sign ? (w_ext - step_ext) : (w_ext + step_ext);
        if (sum > SAT_MAX) begin
            new_w = DATA_W'(SAT_MAX);
        end else if (sum < SAT_MIN) begin
            new_w = DATA_W'(SAT_MIN);
        end else begin
            new_w = DATA_W'(sum);
        end
    end

endmodule

// File: rtl/weight_update_sequencer.sv
// Walks all 65 weight words, applying a read/modify/write step to each.
module weight_update_sequencer
    import nn_pkg::*;
#(
    parameter int unsigned DATA_W   = 10,
    parameter int unsigned ADDR_W   = 7,
    parameter int unsigned LR_SHIFT = 12
) (
    input  logic                     Clock,
    input  logic                     Rst,
    input  logic                     start,
    input  logic        [DATA_W-1:0] delta1   [0:N_OUT-1],
    input  logic        [N_OUT-1:0]  sign1,
    input  logic        [DATA_W-1:0] delta0   [0:N_HID-1],
    input  logic        [N_HID-1:0]  sign0,
    input  logic        [DATA_W-1:0] out0_cal [0:N_HID-1],
    input  logic        [DATA_W-1:0] x_in     [0:N_IN-1],
    output logic        [ADDR_W-1:0] ram_addr,
    output logic                     ram_re,
    input  logic signed [DATA_W-1:0] ram_rdata,
    output logic                     ram_we,
    output logic signed [DATA_W-1:0] ram_wdata,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned OSEL_W = $clog2(N_OUT);
    localparam int unsigned NEU_W  = $clog2(N_HID);
    localparam int unsigned IDX_W  = $clog2(N_IN);

    wus_state_t state, state_nxt;

    logic [DATA_W-1:0] delta1_q [0:N_OUT-1];
    logic [N_OUT-1:0]  sign1_q;
    logic [DATA_W-1:0] delta0_q [0:N_HID-1];
    logic [N_HID-1:0]  sign0_q;
    logic [DATA_W-1:0] out0_q   [0:N_HID-1];
    logic [DATA_W-1:0] x_q      [0:N_IN-1];

    logic              layer;
    logic [NEU_W-1:0]  neuron;
    logic [IDX_W-1:0]  idx;

    logic              start_acc_c;
    logic              last_c;
    logic [DATA_W-1:0] delta_sel_c;
    logic [DATA_W-1:0] act_sel_c;
    logic              sign_sel_c;
    logic signed [DATA_W-1:0] new_w_c;

    assign start_acc_c = (state == ST_IDLE) && start && !Rst;
    assign last_c      = (ram_addr == ADDR_W'(LAST_ADDR));

    // State register.
    always_ff @(posedge Clock) begin
        if (Rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_READ;
            ST_READ:  state_nxt = ST_WAIT;
            ST_WAIT:  state_nxt = ST_WRITE;
            ST_WRITE: state_nxt = last_c ? ST_DONE : ST_READ;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Capture deltas, signs and activations once per pass.
    always_ff @(posedge Clock) begin
        if (start_acc_c) begin
            delta1_q <= delta1;
            sign1_q  <= sign1;
            delta0_q <= delta0;
            sign0_q  <= sign0;
            out0_q   <= out0_cal;
            x_q      <= x_in;
        end
    end

    // Pick delta/activation/sign for the current (layer, neuron, index).
    always_comb begin
        delta_sel_c = '0;
        act_sel_c   = '0;
        sign_sel_c  = 1'b0;
        if (layer) begin
            delta_sel_c = delta1_q[OSEL_W'(neuron)];
            sign_sel_c  = sign1_q[OSEL_W'(neuron)];
            act_sel_c   = out0_q[NEU_W'(idx)];
        end else begin
            delta_sel_c = delta0_q[neuron];
            sign_sel_c  = sign0_q[neuron];
            act_sel_c   = x_q[idx];
        end
    end

    weight_step_alu #(
        .DATA_W   (DATA_W),
        .LR_SHIFT (LR_SHIFT)
    ) u_alu (
        .w     (ram_rdata),
        .delta (delta_sel_c),
        .act   (act_sel_c),
        .sign  (sign_sel_c),
        .new_w (new_w_c)
    );

    // Registered RAM strobes, status flags and address/decode counters.
    always_ff @(posedge Clock) begin
        if (Rst) begin
            ram_addr  <= '0;
            ram_re    <= 1'b0;
            ram_we    <= 1'b0;
            ram_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            layer     <= 1'b0;
            neuron    <= '0;
            idx       <= '0;
        end else begin
            ram_re <= (state_nxt == ST_READ);
            ram_we <= (state_nxt == ST_WRITE);
            busy   <= (state_nxt == ST_READ) || (state_nxt == ST_WAIT) ||
                      (state_nxt == ST_WRITE);
            done   <= (state_nxt == ST_DONE);

            if (state == ST_WAIT) begin
                ram_wdata <= new_w_c;
            end

            if (start_acc_c) begin
                ram_addr <= ADDR_W'(HID_BASE);
                layer    <= 1'b0;
                neuron   <= '0;
                idx      <= '0;
            end else if ((state == ST_WRITE) && !last_c) begin
                ram_addr <= ram_addr + ADDR_W'(1);
                if (!layer) begin
                    if (idx == IDX_W'(N_IN - 1)) begin
                        idx <= '0;
                        if (neuron == NEU_W'(N_HID - 1)) begin
                            neuron   <= '0;
                            layer    <= 1'b1;
                            ram_addr <= ADDR_W'(OUT_BASE);
                        end else begin
                            neuron <= neuron + NEU_W'(1);
                        end
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end else begin
                    if (idx == IDX_W'(N_HID - 1)) begin
                        idx    <= '0;
                        neuron <= neuron + NEU_W'(1);
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_weight_update_sequencer.sv
// Bench for weight_update_sequencer: behavioural RAM plus arithmetic reference model.
module tb_weight_update_sequencer;

    logic              Clock = 1'b0;
    logic              Rst;
    logic              start;
    logic        [9:0] delta1   [0:2];
    logic        [2:0] sign1;
    logic        [9:0] delta0   [0:4];
    logic        [4:0] sign0;
    logic        [9:0] out0_cal [0:4];
    logic        [9:0] x_in     [0:9];
    logic        [6:0] ram_addr;
    logic              ram_re;
    logic signed [9:0] ram_rdata;
    logic              ram_we;
    logic signed [9:0] ram_wdata;
    logic              busy;
    logic              done;

    int checks   = 0;
    int failures = 0;

    logic signed [9:0] mem [0:127];
    bit                wr_seen [0:127];
    int                wr_cnt;
    int                done_cnt = 0;

    int m_d1 [0:2];
    int m_s1 [0:2];
    int m_d0 [0:4];
    int m_s0 [0:4];
    int m_o  [0:4];
    int m_x  [0:9];
    int init_w [0:64];

    weight_update_sequencer dut (
        .Clock     (Clock),
        .Rst       (Rst),
        .start     (start),
        .delta1    (delta1),
        .sign1     (sign1),
        .delta0    (delta0),
        .sign0     (sign0),
        .out0_cal  (out0_cal),
        .x_in      (x_in),
        .ram_addr  (ram_addr),
        .ram_re    (ram_re),
        .ram_rdata (ram_rdata),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .busy      (busy),
        .done      (done)
    );

    always #5 Clock = ~Clock;

    // Synchronous RAM: one-cycle read latency, write on the clock edge.
    always @(posedge Clock) begin
        if (ram_we) begin
            mem[ram_addr] = ram_wdata;
            wr_seen[ram_addr] = 1'b1;
            wr_cnt = wr_cnt + 1;
        end
        if (ram_re) ram_rdata <= mem[ram_addr];
    end

    // Count done pulses.
    always @(negedge Clock) begin
        if (done === 1'b1) done_cnt = done_cnt + 1;
    end

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: decode address by division, then plain integer arithmetic.
    function automatic int expect_w(input int a);
        int d, x, s, step, n;
        if (a < 50) begin
            d = m_d0[a / 10]; x = m_x[a % 10]; s = m_s0[a / 10];
        end else begin
            d = m_d1[(a - 50) / 5]; x = m_o[(a - 50) % 5]; s = m_s1[(a - 50) / 5];
        end
        step = (d * x) / 4096;
        n = (s != 0) ? init_w[a] - step : init_w[a] + step;
        if (n > 511) n = 511;
        if (n < -512) n = -512;
        return n;
    endfunction

    task automatic randomize_inputs();
        for (int i = 0; i < 3; i++) delta1[i] = 10'($urandom_range(0, 1023));
        for (int i = 0; i < 5; i++) delta0[i] = 10'($urandom_range(0, 1023));
        for (int i = 0; i < 5; i++) out0_cal[i] = 10'($urandom_range(0, 1023));
        for (int i = 0; i < 10; i++) x_in[i] = 10'($urandom_range(0, 1023));
        sign1 = 3'($urandom);
        sign0 = 5'($urandom);
    endtask

    task automatic fill_mem(input int hid_w, input int out_w);
        for (int a = 0; a < 128; a++) mem[a] = 10'((a < 50) ? hid_w : out_w);
    endtask

    task automatic fill_mem_random();
        for (int a = 0; a < 128; a++) mem[a] = 10'($urandom_range(0, 1023));
    endtask

    task automatic snapshot();
        for (int i = 0; i < 3; i++) begin m_d1[i] = int'(delta1[i]); m_s1[i] = int'(sign1[i]); end
        for (int i = 0; i < 5; i++) begin
            m_d0[i] = int'(delta0[i]); m_s0[i] = int'(sign0[i]); m_o[i] = int'(out0_cal[i]);
        end
        for (int i = 0; i < 10; i++) m_x[i] = int'(x_in[i]);
        for (int a = 0; a < 65; a++) init_w[a] = int'(mem[a]);
        for (int a = 0; a < 128; a++) wr_seen[a] = 1'b0;
        wr_cnt = 0;
    endtask

    // Issue start; leaves the caller sampling the first cycle after acceptance.
    task automatic pulse_start(input string tag);
        start = 1'b1;
        snapshot();
        @(negedge Clock);
        start = 1'b0;
        check({tag, "_busy_first"}, busy, 1);
        check({tag, "_re_first"}, ram_re, 1);
        check({tag, "_addr_first"}, ram_addr, 0);
    endtask

    task automatic check_mem(input string tag, input int upto);
        for (int a = 0; a < upto; a++)
            check($sformatf("%s_w%0d", tag, a), mem[a], expect_w(a));
    endtask

    // Full pass; optionally perturb inputs and re-pulse start mid-pass.
    task automatic run_pass(input string tag, input int perturb_at);
        int n, dc0;
        dc0 = done_cnt;
        pulse_start(tag);
        n = 0;
        while (done !== 1'b1 && n < 400) begin
            @(negedge Clock);
            n++;
            if (n == perturb_at) begin
                randomize_inputs();
                start = 1'b1;
            end else if (n == perturb_at + 1) begin
                start = 1'b0;
            end
        end
        check({tag, "_done_latency"}, n, 195);
        check({tag, "_busy_at_done"}, busy, 0);
        repeat (6) @(negedge Clock);
        check({tag, "_done_count"}, done_cnt - dc0, 1);
        check({tag, "_write_count"}, wr_cnt, 65);
        check_mem(tag, 65);
    endtask

    initial begin
        int n, late;
        Rst = 1'b1;
        start = 1'b0;
        randomize_inputs();
        fill_mem(0, 0);
        repeat (3) @(negedge Clock);
        check("rst_addr", ram_addr, 0);
        check("rst_re", ram_re, 0);
        check("rst_we", ram_we, 0);
        check("rst_wdata", ram_wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);

        // start coincident with reset is ignored
        start = 1'b1;
        @(negedge Clock);
        Rst = 1'b0;
        start = 1'b0;
        @(negedge Clock);
        check("rst_start_busy", busy, 0);
        check("rst_start_re", ram_re, 0);

        // basic update: 100 + (256*512)>>12 = 132
        for (int i = 0; i < 3; i++) delta1[i] = 10'd256;
        for (int i = 0; i < 5; i++) begin delta0[i] = 10'd256; out0_cal[i] = 10'd512; end
        for (int i = 0; i < 10; i++) x_in[i] = 10'd512;
        sign1 = 3'b000; sign0 = 5'b00000;
        fill_mem(100, 100);
        run_pass("basic", -1);
        check("basic_const_a0", mem[0], 132);
        check("basic_const_a64", mem[64], 132);
        check("wdata_holds", ram_wdata, 132);

        // decrease path on output layer, random signs on hidden layer
        randomize_inputs();
        for (int i = 0; i < 3; i++) delta1[i] = 10'd1023;
        for (int i = 0; i < 5; i++) out0_cal[i] = 10'd1023;
        sign1 = 3'b111;
        fill_mem(500, 500);
        run_pass("decrease", -1);
        check("decrease_a50", mem[50], 245);

        // saturation both directions
        for (int i = 0; i < 3; i++) delta1[i] = 10'd1023;
        for (int i = 0; i < 5; i++) begin delta0[i] = 10'd1023; out0_cal[i] = 10'd1023; end
        for (int i = 0; i < 10; i++) x_in[i] = 10'd1023;
        sign0 = 5'b00000; sign1 = 3'b111;
        fill_mem(500, -500);
        run_pass("saturate", -1);
        check("sat_hi", mem[7], 511);
        check("sat_lo", mem[60], -512);

        // mapping: unique delta/activation per neuron and index
        for (int i = 0; i < 3; i++) delta1[i] = 10'(64 * (i + 1));
        for (int i = 0; i < 5; i++) begin delta0[i] = 10'(64 * (i + 1)); out0_cal[i] = 10'(64 * (i + 1)); end
        for (int i = 0; i < 10; i++) x_in[i] = 10'(64 * (i + 1));
        sign0 = 5'b00000; sign1 = 3'b000;
        fill_mem(0, 0);
        run_pass("mapping", -1);
        check("map_a49", mem[49], (320 * 640) / 4096);
        check("map_a63", mem[63], (192 * 256) / 4096);

        // random passes
        for (int r = 0; r < 3; r++) begin
            randomize_inputs();
            fill_mem_random();
            run_pass($sformatf("rand%0d", r), -1);
        end

        // reset just before the WRITE of address 20
        randomize_inputs();
        fill_mem_random();
        pulse_start("midrst");
        n = 0;
        while (!(ram_addr == 7'd20 && busy && !ram_re && !ram_we) && n < 400) begin
            @(negedge Clock);
            n++;
        end
        check("midrst_reach_wait20", n < 400, 1);
        Rst = 1'b1;
        @(negedge Clock);
        Rst = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_we", ram_we, 0);
        repeat (4) @(negedge Clock);
        check("midrst_idle_busy", busy, 0);
        late = 0;
        for (int a = 20; a < 128; a++) if (wr_seen[a]) late++;
        check("midrst_late_writes", late, 0);
        check("midrst_write_count", wr_cnt, 20);
        check_mem("midrst", 20);
        randomize_inputs();
        run_pass("after_rst", -1);

        // input isolation: change everything and re-pulse start mid-pass
        randomize_inputs();
        fill_mem_random();
        run_pass("isolate", 50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
